spi_rx_word: RTL and testbench

SPI_RX_WORD -- requirements
Module: spi_rx_word

---
 rtl/spi_rx_word.sv | 130 +++++++++++++
 tb/tb_spi_rx_word.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_word.sv
// SPI slave word receiver: synchronizes SCK/SSEL/DATA_IN into clk and assembles MSB-first frames.
// Optional frame counter built only when SPI_RX_FRAME_CNT_EN is defined.
module spi_rx_word #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             SCK,
  input  logic             SSEL,
  input  logic             DATA_IN,
  output logic [WIDTH-1:0] rx_out,
  output logic             rdy,
  output logic             busy,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam logic [1:0] ARM   = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam int         FLUSH = SYNC_STAGES + 2;

  logic [SYNC_STAGES-1:0] sck_sync, ssel_sync, data_sync;
  logic                   sck_d, ssel_d, data_d;
  logic                   sck_rise, ssel_rise, ssel_fall;
  logic [FLUSH-1:0]       flush;
  logic                   sck_s, ssel_s, data_s;

  logic [1:0]             state;
  logic [5:0]             bit_cnt;
  logic [WIDTH-1:0]       shreg;
  logic                   done_good, done_bad;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ssel_s = ssel_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign busy   = (state == SHIFT);

  // Edge strobes are registered so they line up with data_d; flush marks when
  // the chain holds only real pin samples rather than reset idle levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      ssel_sync <= '1;
      data_sync <= '0;
      sck_d     <= 1'b0;
      ssel_d    <= 1'b1;
      data_d    <= 1'b0;
      sck_rise  <= 1'b0;
      ssel_rise <= 1'b0;
      ssel_fall <= 1'b0;
      flush     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sck_sync  <= (sck_sync << 1)  | SYNC_STAGES'(SCK);
      ssel_sync <= (ssel_sync << 1) | SYNC_STAGES'(SSEL);
      data_sync <= (data_sync << 1) | SYNC_STAGES'(DATA_IN);
      sck_d     <= sck_s;
      ssel_d    <= ssel_s;
      data_d    <= data_s;
      sck_rise  <= sck_s & ~sck_d;
      ssel_rise <= ssel_s & ~ssel_d;
      ssel_fall <= ~ssel_s & ssel_d;
      flush     <= {flush[FLUSH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARM;
      bit_cnt   <= '0;
      shreg     <= '0;
      done_good <= 1'b0;
      done_bad  <= 1'b0;
      rx_out    <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rdy       <= 1'b0;
      done_good <= 1'b0;
      done_bad  <= 1'b0;
      if (done_good) begin
        rx_out    <= shreg;
        rdy       <= 1'b1;
        frame_err <= 1'b0;
      end
      if (done_bad) frame_err <= 1'b1;

      case (state)
        ARM: begin
          // Wait for a real idle-high SSEL so a frame in flight at reset release is skipped.
          if (flush[FLUSH-1] && ssel_s && ssel_d) state <= IDLE;
        end
        IDLE: begin
          if (en && ssel_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SHIFT: begin
          if (!en) begin
            state <= IDLE;
          end else if (ssel_rise) begin
            state <= IDLE;
            if (bit_cnt == 6'(WIDTH)) done_good <= 1'b1;
            else                      done_bad  <= 1'b1;
          end else if (sck_rise) begin
            shreg <= {shreg[WIDTH-2:0], data_d};
            if (bit_cnt != 6'(WIDTH + 1)) bit_cnt <= bit_cnt + 6'd1;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

`ifdef SPI_RX_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       frame_cnt <= '0;
    else if (done_good) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_rx_word.sv
// Randomized bench for spi_rx_word against a frame-level reference model.
// Follows SPI_RX_FRAME_CNT_EN to decide whether frame_cnt counts.
module tb_spi_rx_word;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int LATENCY     = SYNC_STAGES + 2;
`ifdef SPI_RX_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b1;
  logic             SCK = 1'b0;
  logic             SSEL = 1'b1;
  logic             DATA_IN = 1'b0;
  logic [WIDTH-1:0] rx_out;
  logic             rdy, busy, frame_err;
  logic [15:0]      frame_cnt;

  spi_rx_word #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .SCK(SCK), .SSEL(SSEL),
    .DATA_IN(DATA_IN), .rx_out(rx_out), .rdy(rdy), .busy(busy),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rdy_cnt = 0;
  int rdy_cyc = 0;
  always @(negedge clk) if (rdy) begin
    rdy_cnt = rdy_cnt + 1;
    rdy_cyc = cyc;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: what the outputs should hold after each whole frame.
  logic [WIDTH-1:0] exp_rx  = '0;
  logic             exp_err = 1'b0;
  logic [15:0]      exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rx"},   rx_out, 32'h0);
    check({tag, "_rdy"},  32'(rdy), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_err"},  32'(frame_err), 32'h0);
    check({tag, "_cnt"},  32'(frame_cnt), 32'h0);
  endtask

  task automatic do_reset(input logic ssel_level);
    SCK = 1'b0; DATA_IN = 1'b0; en = 1'b1; SSEL = ssel_level;
    reset_n = 1'b0;
    wait_clk(3);
    check_zero("reset");
    reset_n = 1'b1;
    exp_rx = '0; exp_err = 1'b0; exp_cnt = '0;
    wait_clk(8);
  endtask

  // ev_kind: 0 none, 1 drop en at ev_bit, 2 pulse reset_n at ev_bit.
  task automatic send_frame(input string tag, input logic [31:0] word, input int nbits,
                            input int half, input int ev_bit, input int ev_kind);
    int ssel_cyc;
    @(negedge clk);
    rdy_cnt = 0;
    SSEL = 1'b0;
    wait_clk(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == ev_bit && ev_kind == 1) begin
        en = 1'b0;
        wait_clk(6);
        check({tag, "_busy_abort"}, 32'(busy), 32'h0);
      end
      if (i == ev_bit && ev_kind == 2) begin
        #2 reset_n = 1'b0;
        #1 check_zero({tag, "_midreset"});
        wait_clk(2);
        reset_n = 1'b1;
        exp_rx = '0; exp_err = 1'b0; exp_cnt = '0;
      end
      DATA_IN = (i < 32) ? word[31-i] : 1'($urandom);
      SCK = 1'b0;
      wait_clk(half);
      SCK = 1'b1;
      wait_clk(half);
      if (i == 1 && ev_kind == 0) check({tag, "_busy"}, 32'(busy), 32'h1);
    end
    SCK = 1'b0;
    wait_clk(half);
    SSEL = 1'b1;
    ssel_cyc = cyc;
    wait_clk(14);
    en = 1'b1;

    if (ev_kind == 0 && nbits == WIDTH) begin
      exp_rx  = word;
      exp_err = 1'b0;
      if (CNT_EN) exp_cnt = exp_cnt + 16'd1;
      check({tag, "_rdy_pulses"}, 32'(rdy_cnt), 32'd1);
      check({tag, "_latency"}, 32'(rdy_cyc - ssel_cyc - 1), 32'(LATENCY));
    end else begin
      if (ev_kind == 0) exp_err = 1'b1;
      check({tag, "_rdy_pulses"}, 32'(rdy_cnt), 32'd0);
    end
    check({tag, "_rx"},   rx_out, exp_rx);
    check({tag, "_err"},  32'(frame_err), 32'(exp_err));
    check({tag, "_cnt"},  32'(frame_cnt), 32'(exp_cnt));
    check({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    int          n, h;

    do_reset(1'b1);

    send_frame("good_3f8", 32'h3F80_0000, 32, 13, -1, 0);
    send_frame("short31",  32'hA5A5_5A5A, 31, 5, -1, 0);
    send_frame("good_1234", 32'h1234_5678, 32, 7, -1, 0);
    send_frame("overrun33", $urandom, 33, 4, -1, 0);
    send_frame("en_abort", $urandom, 32, 5, 10, 1);
    send_frame("good_dead", 32'hDEAD_BEEF, 32, 6, -1, 0);

    for (int k = 0; k < 8; k++) begin
      w = $urandom;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : WIDTH;
      h = $urandom_range(SYNC_STAGES + 1, 9);
      send_frame($sformatf("rand%0d", k), w, n, h, -1, 0);
    end

    // SSEL already low when reset releases: that frame must be ignored.
    do_reset(1'b0);
    rdy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      DATA_IN = 1'($urandom);
      SCK = 1'b0; wait_clk(5);
      SCK = 1'b1; wait_clk(5);
    end
    SCK = 1'b0; wait_clk(5);
    SSEL = 1'b1;
    wait_clk(14);
    check("ssel_low_reset_rdy", 32'(rdy_cnt), 32'd0);
    check_zero("ssel_low_reset");
    send_frame("after_arm", $urandom, 32, 5, -1, 0);

    send_frame("reset_bit16", $urandom, 32, 5, 16, 2);
    send_frame("after_midreset", $urandom, 32, 4, -1, 0);

`ifdef SPI_RX_FRAME_CNT_EN
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    check("preload_cnt", 32'(frame_cnt), 32'h0000_FFFF);
`endif
    send_frame("wrap", $urandom, 32, 5, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
